// File: rtl/mapperram_pkg.sv
// mapperram_pkg
//   Shared definitions for the MSX memory mapper controller:
//   request FSM state encoding, default I/O base port, segment reset
//   values and the pad mask used when segment registers are read back.
package mapperram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_IO_BASE = 8'hFC;

  // Pages 0..3 come out of reset pointing at segments 3,2,1,0.
  localparam logic [7:0] SEG0_RESET = 8'd3;
  localparam logic [7:0] SEG1_RESET = 8'd2;
  localparam logic [7:0] SEG2_RESET = 8'd1;
  localparam logic [7:0] SEG3_RESET = 8'd0;

  function automatic logic [7:0] seg_reset_value(input int page);
    case (page)
      0:       return SEG0_RESET;
      1:       return SEG1_RESET;
      2:       return SEG2_RESET;
      default: return SEG3_RESET;
    endcase
  endfunction

  // Ones in every bit above the implemented segment width.
  function automatic logic [7:0] readback_pad(input int seg_bits);
    logic [8:0] low_ones;
    low_ones = (9'd1 << seg_bits) - 9'd1;
    return ~low_ones[7:0];
  endfunction

endpackage

// File: rtl/ip_mapperram_segreg.sv
// ip_mapperram_segreg
//   Four page segment registers with I/O port decode, page mux and
//   (when MAPPERRAM_READBACK_EN is defined) the readback mux.
// Ports
//   clk, reset      clock / synchronous active-high reset
//   io_port         low byte of the bus address (I/O port number)
//   page_sel        bus_address[15:14]
//   seg_wdata       segment value from the bus write data (already truncated)
//   bus_io          I/O cycle qualifier
//   bus_write       write strobe
//   port_hit        io_port is within IO_BASE..IO_BASE+3
//   page_seg        segment currently mapped to page_sel
//   rb_data         readback byte, upper bits padded with ones (readback build only)
module ip_mapperram_segreg
  import mapperram_pkg::*;
#(
  parameter int         SEG_BITS = 8,
  parameter logic [7:0] IO_BASE  = DEFAULT_IO_BASE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          io_port,
  input  logic [1:0]          page_sel,
  input  logic [SEG_BITS-1:0] seg_wdata,
  input  logic                bus_io,
  input  logic                bus_write,
  output logic                port_hit,
  output logic [SEG_BITS-1:0] page_seg
`ifdef MAPPERRAM_READBACK_EN
  ,
  output logic [7:0]          rb_data
`endif
);

  logic [3:0][SEG_BITS-1:0] seg_all;

  // IO_BASE is 4-aligned, so only the upper six port bits need matching.
  assign port_hit = (io_port[7:2] == IO_BASE[7:2]);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
      localparam logic [7:0] RESET_VAL = seg_reset_value(gi);
      logic [SEG_BITS-1:0] seg_reg;
      logic                seg_we;

      assign seg_we = bus_io & bus_write & port_hit & (io_port[1:0] == 2'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          seg_reg <= RESET_VAL[SEG_BITS-1:0];
        end else if (seg_we) begin
          seg_reg <= seg_wdata;
        end
      end

      assign seg_all[gi] = seg_reg;
    end
  endgenerate

  assign page_seg = seg_all[page_sel];

`ifdef MAPPERRAM_READBACK_EN
  assign rb_data = readback_pad(SEG_BITS) | 8'(seg_all[io_port[1:0]]);
`endif

endmodule

// File: rtl/ip_mapperram_ctrl.sv
// ip_mapperram_ctrl
//   MSX memory mapper controller between the MSX-50BUS slot decoder and
//   an external RAM controller. Maps the four 16KB CPU pages through
//   segment registers at I/O ports IO_BASE..IO_BASE+3 and issues exactly
//   one RAM read or write per bus memory access.
//   Optional feature macro: MAPPERRAM_READBACK_EN (I/O readback of segments).
// Ports
//   clk, reset                     clock / synchronous active-high reset
//   bus_address                    [15:14] page, [13:0] offset, [7:0] I/O port
//   bus_io_cs, bus_memory_cs       chip selects toward the slot decoder
//   bus_read_ready, bus_read_data  one-cycle read-valid pulse and held data
//   bus_write_data                 write data from the bus
//   bus_read, bus_write            level strobes, held for the whole access
//   bus_io, bus_memory             cycle qualifiers
//   rd, wr                         RAM requests, held until accepted (!busy)
//   busy                           RAM busy
//   address, wdata                 latched RAM byte address and write data
//   rdata, rdata_en                RAM read data and its valid strobe
module ip_mapperram_ctrl
  import mapperram_pkg::*;
#(
  parameter int         SEG_BITS = 8,
  parameter logic [7:0] IO_BASE  = DEFAULT_IO_BASE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            bus_address,
  output logic                   bus_io_cs,
  output logic                   bus_memory_cs,
  output logic                   bus_read_ready,
  output logic [7:0]             bus_read_data,
  input  logic [7:0]             bus_write_data,
  input  logic                   bus_read,
  input  logic                   bus_write,
  input  logic                   bus_io,
  input  logic                   bus_memory,
  output logic                   rd,
  output logic                   wr,
  input  logic                   busy,
  output logic [SEG_BITS+13:0]   address,
  output logic [7:0]             wdata,
  input  logic [7:0]             rdata,
  input  logic                   rdata_en
);

  state_t                state_reg, state_next;
  logic                  op_write_reg;
  logic [SEG_BITS+13:0]  address_reg;
  logic [7:0]            wdata_reg;
  logic [7:0]            read_data_reg;
  logic                  read_ready_reg;

  logic                  port_hit;
  logic [SEG_BITS-1:0]   page_seg;
  logic                  mem_req;
  logic                  io_rd;
`ifdef MAPPERRAM_READBACK_EN
  logic [7:0]            rb_data;
`endif

  ip_mapperram_segreg #(
    .SEG_BITS (SEG_BITS),
    .IO_BASE  (IO_BASE)
  ) u_segreg (
    .clk       (clk),
    .reset     (reset),
    .io_port   (bus_address[7:0]),
    .page_sel  (bus_address[15:14]),
    .seg_wdata (bus_write_data[SEG_BITS-1:0]),
    .bus_io    (bus_io),
    .bus_write (bus_write),
    .port_hit  (port_hit),
    .page_seg  (page_seg)
`ifdef MAPPERRAM_READBACK_EN
    ,
    .rb_data   (rb_data)
`endif
  );

  // bus_io excludes the memory path, so an I/O cycle always wins.
  assign mem_req = bus_memory & (bus_read ^ bus_write) & ~bus_io;

`ifdef MAPPERRAM_READBACK_EN
  assign io_rd     = bus_io & bus_read & ~bus_write & port_hit;
  assign bus_io_cs = port_hit;
`else
  assign io_rd     = 1'b0;
  assign bus_io_cs = port_hit & bus_write;
`endif

  assign bus_memory_cs = 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (io_rd) begin
          state_next = RELEASE;
        end else if (mem_req) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!busy) begin
          state_next = op_write_reg ? RELEASE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rdata_en) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // Held strobes park here so one bus access yields one RAM access.
        if (!bus_read && !bus_write) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd = 1'b0;
    wr = 1'b0;
    if (state_reg == REQ) begin
      rd = ~op_write_reg;
      wr = op_write_reg;
    end
  end

  // Request latches and read-return path. Latches only load in IDLE so a
  // segment write during an outstanding request cannot move its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_write_reg   <= 1'b0;
      address_reg    <= '0;
      wdata_reg      <= 8'h00;
      read_data_reg  <= 8'h00;
      read_ready_reg <= 1'b0;
    end else begin
      read_ready_reg <= 1'b0;
      if (state_reg == IDLE && mem_req) begin
        op_write_reg <= bus_write;
        address_reg  <= {page_seg, bus_address[13:0]};
        wdata_reg    <= bus_write_data;
      end
`ifdef MAPPERRAM_READBACK_EN
      if (state_reg == IDLE && io_rd) begin
        read_data_reg  <= rb_data;
        read_ready_reg <= 1'b1;
      end
`endif
      if (state_reg == WAIT_RD && rdata_en) begin
        read_data_reg  <= rdata;
        read_ready_reg <= 1'b1;
      end
    end
  end

  assign address        = address_reg;
  assign wdata          = wdata_reg;
  assign bus_read_data  = read_data_reg;
  assign bus_read_ready = read_ready_reg;

endmodule

// File: tb/tb_ip_mapperram_ctrl.sv
module tb_ip_mapperram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read, bus_write, bus_io, bus_memory;
  logic        busy;
  logic [7:0]  rdata;
  logic        rdata_en;

  logic        bus_io_cs, bus_memory_cs, bus_read_ready, rd, wr;
  logic [7:0]  bus_read_data, wdata;
  logic [21:0] address;

  logic        bus_io_cs4, bus_memory_cs4, bus_read_ready4, rd4, wr4;
  logic [7:0]  bus_read_data4, wdata4;
  logic [17:0] address4;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ip_mapperram_ctrl #(.SEG_BITS(8)) dut (
    .clk(clk), .reset(reset), .bus_address(bus_address),
    .bus_io_cs(bus_io_cs), .bus_memory_cs(bus_memory_cs),
    .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data),
    .bus_write_data(bus_write_data), .bus_read(bus_read), .bus_write(bus_write),
    .bus_io(bus_io), .bus_memory(bus_memory), .rd(rd), .wr(wr), .busy(busy),
    .address(address), .wdata(wdata), .rdata(rdata), .rdata_en(rdata_en)
  );

  ip_mapperram_ctrl #(.SEG_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .bus_address(bus_address),
    .bus_io_cs(bus_io_cs4), .bus_memory_cs(bus_memory_cs4),
    .bus_read_ready(bus_read_ready4), .bus_read_data(bus_read_data4),
    .bus_write_data(bus_write_data), .bus_read(bus_read), .bus_write(bus_write),
    .bus_io(bus_io), .bus_memory(bus_memory), .rd(rd4), .wr(wr4), .busy(busy),
    .address(address4), .wdata(wdata4), .rdata(rdata), .rdata_en(rdata_en)
  );

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        is_wr;
    logic [7:0]  wd;
    logic [7:0]  rdv;
    logic [21:0] exp_a;
    logic [17:0] exp_a4;
  } mem_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic        rd;
    logic        exp_cs;
  } cs_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus_read = 0; bus_write = 0; bus_io = 0; bus_memory = 0;
    busy = 0; rdata_en = 0;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] d, input logic mem_also);
    bus_address = addr; bus_write_data = d;
    bus_io = 1; bus_write = 1; bus_memory = mem_also;
    tick();
    check("io_wr_no_req_a", {30'd0, rd, wr}, 32'd0);
    tick();
    check("io_wr_no_req_b", {30'd0, rd, wr}, 32'd0);
    idle_bus();
    tick();
    $display("[TB] io write port=%h data=%h", addr[7:0], d);
  endtask

  // One complete bus memory access; busy is held high for the first
  // busy_cyc request cycles, so the request should be seen busy_cyc+1 cycles.
  task automatic mem_op(input string name, input logic [15:0] addr, input logic is_wr,
                        input logic [7:0] wd, input int busy_cyc, input logic [7:0] rdv,
                        input logic [21:0] exp_a, input logic [17:0] exp_a4);
    int req_cnt = 0;
    int acc_cnt = 0;
    int extra   = 0;
    bus_address = addr; bus_write_data = wd;
    bus_io = 0; bus_memory = 1; bus_read = ~is_wr; bus_write = is_wr; busy = 1;
    tick();
    check({name, "_addr"}, 32'(address), 32'(exp_a));
    check({name, "_addr4"}, 32'(address4), 32'(exp_a4));
    check({name, "_req"}, {30'd0, rd, wr}, is_wr ? 32'd1 : 32'd2);
    if (is_wr) check({name, "_wdata"}, 32'(wdata), 32'(wd));
    for (int c = 0; c < 50; c++) begin
      if (!(rd | wr)) break;
      req_cnt++;
      busy = (req_cnt <= busy_cyc);
      if (!busy) acc_cnt++;
      tick();
    end
    busy = 0;
    check({name, "_req_cycles"}, 32'(req_cnt), 32'(busy_cyc + 1));
    check({name, "_accepts"}, 32'(acc_cnt), 32'd1);
    if (!is_wr) begin
      check({name, "_no_early_ready"}, 32'(bus_read_ready), 32'd0);
      rdata = rdv; rdata_en = 1;
      tick();
      rdata_en = 0;
      check({name, "_ready"}, 32'(bus_read_ready), 32'd1);
      check({name, "_rdata"}, 32'(bus_read_data), 32'(rdv));
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rd | wr) extra++;
      if (bus_read_ready) extra++;
    end
    check({name, "_no_dup"}, 32'(extra), 32'd0);
    idle_bus();
    tick();
    tick();
    $display("[TB] %s %s addr=%h ram_addr=%h", name, is_wr ? "write" : "read", addr, exp_a);
  endtask

  mem_vec_t mem_tbl [4];
  cs_vec_t  cs_tbl  [6];
  logic [7:0] held_data4;
  int pulses;

  initial begin
    mem_tbl[0] = '{"page0", 16'h0000, 1'b0, 8'h00, 8'h11, 22'h00C000, 18'h0C000};
    mem_tbl[1] = '{"page1", 16'h4123, 1'b1, 8'h3C, 8'h00, 22'h008123, 18'h08123};
    mem_tbl[2] = '{"page2", 16'h8000, 1'b0, 8'h00, 8'hC3, 22'h004000, 18'h04000};
    mem_tbl[3] = '{"page3", 16'hC00F, 1'b1, 8'h81, 8'h00, 22'h00000F, 18'h0000F};

    cs_tbl[0] = '{16'h00FC, 1'b1, 1'b0, 1'b1};
    cs_tbl[1] = '{16'h00FF, 1'b1, 1'b0, 1'b1};
    cs_tbl[2] = '{16'h00FB, 1'b1, 1'b0, 1'b0};
    cs_tbl[3] = '{16'h0000, 1'b1, 1'b0, 1'b0};
    cs_tbl[4] = '{16'h12FE, 1'b1, 1'b0, 1'b1};
`ifdef MAPPERRAM_READBACK_EN
    cs_tbl[5] = '{16'h00FD, 1'b0, 1'b1, 1'b1};
`else
    cs_tbl[5] = '{16'h00FD, 1'b0, 1'b1, 1'b0};
`endif

    reset = 1; bus_address = 0; bus_write_data = 0; rdata = 0;
    idle_bus();
    tick(); tick();
    reset = 0;
    check("rst_rd_wr", {30'd0, rd, wr}, 32'd0);
    check("rst_ready", 32'(bus_read_ready), 32'd0);
    check("rst_rdata", 32'(bus_read_data), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("memory_cs", 32'(bus_memory_cs), 32'd1);

    // Chip-select decode, no qualifiers so nothing is written or captured.
    foreach (cs_tbl[i]) begin
      bus_address = cs_tbl[i].addr; bus_write = cs_tbl[i].wr; bus_read = cs_tbl[i].rd;
      #1;
      check($sformatf("io_cs_%0d", i), 32'(bus_io_cs), 32'(cs_tbl[i].exp_cs));
      $display("[TB] io_cs addr=%h wr=%0d rd=%0d cs=%0d", cs_tbl[i].addr, cs_tbl[i].wr, cs_tbl[i].rd, bus_io_cs);
    end
    idle_bus();
    tick();

    // Basic read through page 2 (seg 1) with two busy cycles.
    mem_op("t1_read", 16'h8000, 1'b0, 8'h00, 2, 8'h5A, 22'h004000, 18'h04000);

    // Reset-value mapping of every page.
    foreach (mem_tbl[i])
      mem_op(mem_tbl[i].name, mem_tbl[i].addr, mem_tbl[i].is_wr, mem_tbl[i].wd, 0,
             mem_tbl[i].rdv, mem_tbl[i].exp_a, mem_tbl[i].exp_a4);

    // Segment write to page 2, then a held write through it.
    io_write(16'h00FE, 8'h23, 1'b0);
    mem_op("t2_write", 16'hBFFF, 1'b1, 8'hA5, 0, 8'h00, 22'h08FFFF, 18'h0FFFF);

    // Long busy stall.
    mem_op("t3_busy5", 16'hC123, 1'b0, 8'h00, 5, 8'h69, 22'h000123, 18'h00123);

    // I/O and memory qualifiers together: only the segment write happens.
    io_write(16'h00FD, 8'h77, 1'b1);
    mem_op("t6_seg1", 16'h4000, 1'b0, 8'h00, 0, 8'h96, 22'h1DC000, 18'h1C000);

    // Truncation of wide segment values (SEG_BITS=4 instance keeps 7).
    io_write(16'h00FC, 8'hF7, 1'b0);
    held_data4 = bus_read_data4;
    bus_address = 16'h00FC; bus_io = 1; bus_read = 1;
    pulses = 0;
    tick();
`ifdef MAPPERRAM_READBACK_EN
    check("t4_rb_ready", 32'(bus_read_ready4), 32'd1);
    check("t4_rb_data4", 32'(bus_read_data4), 32'hF7);
    check("t4_rb_data8", 32'(bus_read_data), 32'hF7);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus_read_ready4) pulses++;
    end
    check("t4_rb_single", 32'(pulses), 32'd0);
`else
    for (int c = 0; c < 3; c++) begin
      if (bus_read_ready4) pulses++;
      tick();
    end
    check("t4_no_rb_pulse", 32'(pulses), 32'd0);
    check("t4_rb_data_held", 32'(bus_read_data4), 32'(held_data4));
`endif
    idle_bus();
    tick();
    $display("[TB] io read port=fc data4=%h", bus_read_data4);
    mem_op("t4_seg0", 16'h0000, 1'b0, 8'h00, 0, 8'h42, 22'h3DC000, 18'h1C000);

    // Reset while waiting for read data; the late rdata_en must be dropped.
    bus_address = 16'h8000; bus_memory = 1; bus_read = 1; busy = 0;
    tick();
    check("t5_rd_req", 32'(rd), 32'd1);
    tick();
    check("t5_accepted", 32'(rd), 32'd0);
    reset = 1; bus_read = 0; bus_memory = 0;
    tick();
    reset = 0;
    rdata = 8'hEE; rdata_en = 1;
    tick();
    rdata_en = 0;
    check("t5_no_ready", 32'(bus_read_ready), 32'd0);
    check("t5_rd_low", 32'(rd), 32'd0);
    check("t5_rdata_rst", 32'(bus_read_data), 32'd0);
    tick();
    check("t5_no_ready_late", 32'(bus_read_ready), 32'd0);
    $display("[TB] reset during WAIT_RD");
    mem_op("t5_post_reset", 16'h0010, 1'b0, 8'h00, 0, 8'h3C, 22'h00C010, 18'h0C010);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
